// File: rtl/cdc_sync_data_ack_rx_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : cdc_sync_data_ack_rx_pkg
//  Description : Shared definitions for the closed-loop toggle req/ack data
//                crossing. Holds the FSM state encoding, the default
//                synchronizer depth and a counter-width helper. The same
//                package is used by the source-side initiator.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package cdc_sync_data_ack_rx_pkg;

    // Default metastability chain depth for toggle synchronizers.
    localparam int DEFAULT_SYNC_STAGES = 2;

    // FSM state encoding, explicit 2-bit width.
    localparam int         CDC_STATE_W   = 2;
    localparam logic [1:0] CDC_ST_IDLE   = 2'd0;
    localparam logic [1:0] CDC_ST_SETTLE = 2'd1;
    localparam logic [1:0] CDC_ST_VALID  = 2'd2;

    typedef enum logic [CDC_STATE_W-1:0] {
        ST_IDLE   = CDC_ST_IDLE,
        ST_SETTLE = CDC_ST_SETTLE,
        ST_VALID  = CDC_ST_VALID
    } cdc_state_e;

    // Width of a down-counter that must hold values 0 .. cycles-1.
    // Always at least one bit so the counter exists even when unused.
    function automatic int settle_cnt_width(input int cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cdc_sync_bits.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : cdc_sync_bits
//  Description : Multi-flop synchronizer for quasi-static or toggle signals
//                entering the clk domain. Each bit is synchronized
//                independently; no coherency between bits is implied.
//  Ports       : clk     - destination clock
//                rst     - asynchronous active-high reset (chain clears to 0)
//                i_bits  - asynchronous input bits
//                o_bits  - synchronized bits, SYNC_STAGES flops later
//  Revision    : 1.0 - initial release
// ============================================================================
module cdc_sync_bits #(
    parameter int NUM_BITS    = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_BITS-1:0] i_bits,
    output logic [NUM_BITS-1:0] o_bits
);

    // Stage 0 is the metastable capture flop; stage SYNC_STAGES-1 is the
    // output. Depth must be at least 2.
    (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0][NUM_BITS-1:0] sync_q;
    logic [SYNC_STAGES-1:0][NUM_BITS-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], i_bits};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign o_bits = sync_q[SYNC_STAGES-1];

endmodule
`default_nettype wire

// File: rtl/cdc_sync_data_ack_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : cdc_sync_data_ack_rx
//  Description : Destination-side responder of a closed-loop toggle
//                request / toggle acknowledge data crossing. Synchronizes the
//                request toggle, waits SETTLE_CYCLES, captures the
//                source-held bus once and presents it on valid/ready. The
//                acknowledge toggle is returned only when the word is
//                consumed, so throughput follows downstream backpressure.
//  Ports       : clk_out  - destination clock (only clock)
//                reset    - asynchronous active-high reset
//                req_in   - request toggle from source domain (async)
//                bits_in  - source-held data (async, stable while pending)
//                ack_out  - acknowledge toggle to source (registered)
//                valid    - bits_out holds an unconsumed word
//                ready    - downstream accepts when valid && ready
//                bits_out - captured data (registered)
//                busy     - FSM not idle
//                overrun  - sticky: request toggled while not idle
//  Revision    : 1.0 - initial release
// ============================================================================
module cdc_sync_data_ack_rx
    import cdc_sync_data_ack_rx_pkg::*;
#(
    parameter int NUM_BITS      = 1,
    parameter int SYNC_STAGES   = DEFAULT_SYNC_STAGES,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                clk_out,
    input  logic                reset,
    input  logic                req_in,
    input  logic [NUM_BITS-1:0] bits_in,
    output logic                ack_out,
    output logic                valid,
    input  logic                ready,
    output logic [NUM_BITS-1:0] bits_out,
    output logic                busy,
    output logic                overrun
);

    localparam int CNT_W = settle_cnt_width(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0] SETTLE_LOAD =
        (SETTLE_CYCLES > 0) ? CNT_W'(SETTLE_CYCLES - 1) : '0;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // ------------------------------------------------------------------
    // Request synchronizer
    // ------------------------------------------------------------------
    logic req_sync;

    cdc_sync_bits #(
        .NUM_BITS    (1),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_req_sync (
        .clk    (clk_out),
        .rst    (reset),
        .i_bits (req_in),
        .o_bits (req_sync)
    );

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    cdc_state_e          state_q,        state_d;
    logic [CNT_W-1:0]    cnt_q,          cnt_d;
    logic                ack_q,          ack_d;
    logic                valid_q,        valid_d;
    logic                busy_q,         busy_d;
    logic                overrun_q,      overrun_d;
    logic                req_sync_dly_q, req_sync_dly_d;
    // Capture register: bits_in is held stable by the source protocol for
    // the whole time the request is pending, so the path into this flop is
    // timed as a false path.
    (* false_path = "true" *) logic [NUM_BITS-1:0] bits_q;
    logic [NUM_BITS-1:0] bits_d;

    logic pending;
    logic req_edge;

    // A request is outstanding while the synced toggle disagrees with the
    // last acknowledge we returned. Toggling ack clears it in the same cycle.
    assign pending  = req_sync ^ ack_q;
    assign req_edge = req_sync ^ req_sync_dly_q;

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        ack_d          = ack_q;
        valid_d        = valid_q;
        bits_d         = bits_q;
        req_sync_dly_d = req_sync;

        // Any request transition seen while a word is in flight means the
        // source broke the handshake; that request is lost.
        overrun_d = overrun_q | (req_edge & (state_q != ST_IDLE));

        case (state_q)
            ST_IDLE: begin
                if (pending) begin
                    if (SETTLE_CYCLES > 0) begin
                        cnt_d   = SETTLE_LOAD;
                        state_d = ST_SETTLE;
                    end else begin
                        bits_d  = bits_in;
                        valid_d = 1'b1;
                        state_d = ST_VALID;
                    end
                end
            end

            ST_SETTLE: begin
                if (cnt_q == '0) begin
                    bits_d  = bits_in;
                    valid_d = 1'b1;
                    state_d = ST_VALID;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end

            ST_VALID: begin
                if (valid_q && ready) begin
                    valid_d = 1'b0;
                    ack_d   = ~ack_q;
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
            end
        endcase

        // busy is registered from the next state so it tracks state_q exactly.
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk_out or posedge reset) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            ack_q          <= 1'b0;
            valid_q        <= 1'b0;
            bits_q         <= '0;
            busy_q         <= 1'b0;
            overrun_q      <= 1'b0;
            req_sync_dly_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            ack_q          <= ack_d;
            valid_q        <= valid_d;
            bits_q         <= bits_d;
            busy_q         <= busy_d;
            overrun_q      <= overrun_d;
            req_sync_dly_q <= req_sync_dly_d;
        end
    end

    assign ack_out  = ack_q;
    assign valid    = valid_q;
    assign bits_out = bits_q;
    assign busy     = busy_q;
    assign overrun  = overrun_q;

endmodule
`default_nettype wire
